// File: rtl/tx_pkg.sv
// Shared constants and helpers for the 4-ASK transmit front end: Gray level map,
// PRBS-7 generator step and the per-slot action encoding.
package tx_pkg;

  localparam int LVL_W = 18;

  localparam logic signed [LVL_W-1:0] LVL_M3 = -18'sd98304;
  localparam logic signed [LVL_W-1:0] LVL_M1 = -18'sd32768;
  localparam logic signed [LVL_W-1:0] LVL_P1 =  18'sd32768;
  localparam logic signed [LVL_W-1:0] LVL_P3 =  18'sd98304;

  // x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_FIFO,
    SLOT_PRBS,
    SLOT_STARVE
  } slot_act_e;

  function automatic logic signed [LVL_W-1:0] gray_map(input logic [1:0] sym);
    logic signed [LVL_W-1:0] lvl;
    case (sym)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      default: lvl = LVL_P3;
    endcase
    return lvl;
  endfunction

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small symbol FIFO with valid/ready write side and pop/empty read side.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_valid_i,
  input  logic [W-1:0] wr_data_i,
  output logic         wr_ready_o,
  input  logic         rd_pop_i,
  output logic         rd_empty_o,
  output logic [W-1:0] rd_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         full;
  logic         wr_en;
  logic         rd_en;

  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_empty_o = (wr_ptr_q == rd_ptr_q);
  assign wr_ready_o = !full;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Both qualifiers come from registered pointers, so a pop on a full FIFO
  // cannot admit a write in the same cycle and a write cannot feed a pop on empty.
  assign wr_en = wr_valid_i && !full;
  assign rd_en = rd_pop_i && !rd_empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/tx_sym_upsampler.sv
// 4-ASK transmit front end: buffers symbols (or draws PRBS-7), Gray-maps them to
// 1s17 levels and zero-stuffs by UPS at the sample strobe rate.
module tx_sym_upsampler
  import tx_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int UPS        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int UFL_CNT_W  = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    sam_clk_en,
  input  logic                    tx_en,
  input  logic                    prbs_en,
  input  logic [1:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    sym_strobe,
  output logic                    underflow,
  output logic [UFL_CNT_W-1:0]    ufl_count,
  input  logic                    clr_ufl
);

  localparam int PH_W = (UPS > 1) ? $clog2(UPS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPS - 1);

  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic                    strobe_q, strobe_d;
  logic                    ufl_q, ufl_d;
  logic [UFL_CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]              lfsr_q, lfsr_d;

  logic       fifo_empty;
  logic [1:0] fifo_data;
  logic       fifo_pop;
  slot_act_e  act;

  sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_n_i    (reset_n),
    .wr_valid_i (sym_valid),
    .wr_data_i  (sym_in),
    .wr_ready_o (sym_ready),
    .rd_pop_i   (fifo_pop),
    .rd_empty_o (fifo_empty),
    .rd_data_o  (fifo_data)
  );

  always_comb begin
    act = SLOT_IDLE;
    if (sam_clk_en && tx_en && (phase_q == '0)) begin
      if (prbs_en)          act = SLOT_PRBS;
      else if (!fifo_empty) act = SLOT_FIFO;
      else                  act = SLOT_STARVE;
    end
  end

  assign fifo_pop = (act == SLOT_FIFO);

  always_comb begin
    phase_d  = phase_q;
    y_d      = y_q;
    strobe_d = 1'b0;
    ufl_d    = ufl_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    if (sam_clk_en) begin
      y_d = '0;
      if (!tx_en) begin
        phase_d = '0;
      end else begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        case (act)
          SLOT_FIFO: begin
            y_d      = WIDTH'(gray_map(fifo_data));
            strobe_d = 1'b1;
          end
          SLOT_PRBS: begin
            y_d      = WIDTH'(gray_map(lfsr_q[1:0]));
            strobe_d = 1'b1;
            lfsr_d   = prbs7_step(prbs7_step(lfsr_q));
          end
          SLOT_STARVE: begin
            ufl_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + UFL_CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
    // A clear on the same edge as a starved slot discards that event.
    if (clr_ufl) begin
      ufl_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      y_q      <= '0;
      strobe_q <= 1'b0;
      ufl_q    <= 1'b0;
      cnt_q    <= '0;
      lfsr_q   <= PRBS7_SEED;
    end else begin
      phase_q  <= phase_d;
      y_q      <= y_d;
      strobe_q <= strobe_d;
      ufl_q    <= ufl_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign y          = y_q;
  assign sym_strobe = strobe_q;
  assign underflow  = ufl_q;
  assign ufl_count  = cnt_q;

endmodule

// File: tb/tb_tx_sym_upsampler.sv
// Directed self-checking bench for tx_sym_upsampler with hand-computed levels,
// including a hand-stepped PRBS-7 sequence from seed 7'h7F.
module tb_tx_sym_upsampler;

  logic               sys_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sam_clk_en = 1'b0;
  logic               tx_en = 1'b0;
  logic               prbs_en = 1'b0;
  logic [1:0]         sym_in = 2'b00;
  logic               sym_valid = 1'b0;
  logic               sym_ready;
  logic signed [17:0] y;
  logic               sym_strobe;
  logic               underflow;
  logic [15:0]        ufl_count;
  logic               clr_ufl = 1'b0;

  int tests = 0;
  int fails = 0;

  tx_sym_upsampler #(
    .WIDTH(18), .UPS(4), .FIFO_DEPTH(4), .UFL_CNT_W(16)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .sam_clk_en (sam_clk_en),
    .tx_en      (tx_en),
    .prbs_en    (prbs_en),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .y          (y),
    .sym_strobe (sym_strobe),
    .underflow  (underflow),
    .ufl_count  (ufl_count),
    .clr_ufl    (clr_ufl)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic strobe();
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] s);
    sym_in    = s;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    tick();
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  longint t1_exp [16] = '{-98304, 0, 0, 0, -32768, 0, 0, 0,
                           32768, 0, 0, 0,  98304, 0, 0, 0};
  // Seed 7F, two shifts per symbol: states 7F,7C,70,40,02,08,20,03
  longint prbs_exp [8] = '{32768, -98304, -98304, -98304,
                            98304, -98304, -98304, 32768};

  initial begin
    int acc;
    tick();
    #2;
    reset_n = 1'b1;
    tick();

    chk("rst_y", longint'(y), 0);
    chk("rst_strobe", longint'(sym_strobe), 0);
    chk("rst_ufl", longint'(underflow), 0);
    chk("rst_cnt", longint'(ufl_count), 0);
    chk("rst_ready", longint'(sym_ready), 1);

    // Gray map and zero stuffing, strobe every 8 clocks
    tx_en = 1'b1;
    push(2'b00);
    push(2'b01);
    push(2'b11);
    push(2'b10);
    for (int i = 0; i < 16; i++) begin
      strobe();
      chk($sformatf("map_y%0d", i), longint'(y), t1_exp[i]);
      chk($sformatf("map_stb%0d", i), longint'(sym_strobe), (t1_exp[i] != 0) ? 1 : 0);
      tick();
      chk($sformatf("map_hold%0d", i), longint'(y), t1_exp[i]);
      chk($sformatf("map_stbdrop%0d", i), longint'(sym_strobe), 0);
      for (int k = 0; k < 6; k++) tick();
    end
    chk("map_no_ufl", longint'(underflow), 0);

    // Backpressure: 4 writes accepted, then ready low
    acc = 0;
    sym_in    = 2'b10;
    sym_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (sym_ready) acc++;
      tick();
    end
    chk("bp_accepts", longint'(acc), 4);
    chk("bp_ready_low", longint'(sym_ready), 0);
    strobe();
    chk("bp_ready_back", longint'(sym_ready), 1);
    chk("bp_pop_y", longint'(y), 98304);
    sym_valid = 1'b0;

    // Async reset between clocks with 3 entries held
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_y", longint'(y), 0);
    chk("arst_ready", longint'(sym_ready), 1);
    tick();
    #2;
    reset_n = 1'b1;
    tick();

    // Starved slots: FIFO empty after reset, phase 0
    for (int s = 0; s < 3; s++) begin
      strobe();
      chk($sformatf("ufl_y%0d", s), longint'(y), 0);
      chk($sformatf("ufl_stb%0d", s), longint'(sym_strobe), 0);
      for (int k = 0; k < 3; k++) strobe();
    end
    chk("ufl_flag", longint'(underflow), 1);
    chk("ufl_cnt3", longint'(ufl_count), 3);
    clr_ufl = 1'b1;
    tick();
    clr_ufl = 1'b0;
    chk("clr_flag", longint'(underflow), 0);
    chk("clr_cnt", longint'(ufl_count), 0);
    clr_ufl = 1'b1;
    strobe();
    clr_ufl = 1'b0;
    chk("clr_wins_flag", longint'(underflow), 0);
    chk("clr_wins_cnt", longint'(ufl_count), 0);
    for (int k = 0; k < 3; k++) strobe();
    strobe();
    chk("ufl_after_clr", longint'(ufl_count), 1);

    // PRBS source from reset; FIFO keeps its two entries
    prbs_en = 1'b1;
    do_reset();
    push(2'b01);
    push(2'b11);
    for (int i = 0; i < 8; i++) begin
      strobe();
      chk($sformatf("prbs_y%0d", i), longint'(y), prbs_exp[i]);
      chk($sformatf("prbs_stb%0d", i), longint'(sym_strobe), 1);
      for (int k = 0; k < 3; k++) begin
        strobe();
        chk($sformatf("prbs_zero%0d_%0d", i, k), longint'(y), 0);
      end
    end
    chk("prbs_no_ufl", longint'(underflow), 0);
    prbs_en = 1'b0;
    strobe();
    chk("occ_first", longint'(y), -32768);
    chk("occ_first_stb", longint'(sym_strobe), 1);

    // tx_en dropped at phase 2, next FIFO symbol on first re-enabled strobe
    strobe();
    tx_en = 1'b0;
    strobe();
    chk("txoff_y", longint'(y), 0);
    chk("txoff_stb", longint'(sym_strobe), 0);
    tx_en = 1'b1;
    strobe();
    chk("txon_y", longint'(y), 32768);
    chk("txon_stb", longint'(sym_strobe), 1);
    strobe();
    chk("txon_stuff", longint'(y), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
